// File: rtl/pixel_dispatcher.sv
// Hands out frame pixels in raster order to four ray units, strictly round-robin.
// One job is offered at a time; the shared coordinates stay put until the addressed unit takes it.
module pixel_dispatcher #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  unit_ready,
    output logic [3:0]  unit_valid,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    // state | meaning
    // IDLE  | waiting for start
    // ISSUE | offering pixel (pix_x, pix_y) to unit cur_unit
    // DONE  | last pixel taken, frame_done pulses this cycle
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [10:0] X_LAST = 11'(H_RES - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_RES - 1);

    state_t      state_q, state_d;
    logic [10:0] pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic [1:0]  cur_unit_q, cur_unit_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic xfer;
    logic last_pix;

    assign xfer     = (state_q == S_ISSUE) && unit_ready[cur_unit_q];
    assign last_pix = (pix_x_q == X_LAST) && (pix_y_q == Y_LAST);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            cur_unit_q    <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            cur_unit_q    <= cur_unit_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (abort)                 state_d = S_IDLE;
                else if (xfer && last_pix) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A transfer coinciding with abort still advances the position; the next start reloads it anyway.
    always_comb begin
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        cur_unit_d    = cur_unit_q;
        frame_count_d = frame_count_q;
        if (state_q == S_IDLE) begin
            if (start && !abort) begin
                pix_x_d    = '0;
                pix_y_d    = '0;
                cur_unit_d = '0;
            end
        end else if (xfer) begin
            cur_unit_d = cur_unit_q + 2'd1;
            if (!last_pix) begin
                if (pix_x_q == X_LAST) begin
                    pix_x_d = '0;
                    pix_y_d = pix_y_q + 10'd1;
                end else begin
                    pix_x_d = pix_x_q + 11'd1;
                end
            end else if (!abort) begin
                frame_count_d = frame_count_q + 16'd1;
            end
        end
    end

    always_comb begin
        unit_valid = '0;
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_DONE);
        if (state_q == S_ISSUE) unit_valid = 4'b0001 << cur_unit_q;
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Scoreboarded bench for pixel_dispatcher on a 4x2 frame: every accepted job is
// popped against the raster-order expectation pushed when the frame was started.
`timescale 1ns/1ps
module tb_pixel_dispatcher;

    localparam int H = 4;
    localparam int V = 2;
    localparam int NPIX = H * V;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        abort;
    logic [3:0]  unit_ready;
    logic [3:0]  unit_valid;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
        logic [2:0]  u;
    } job_t;

    job_t        exp_q[$];
    int          n_cmp;
    int          n_err;
    int          n_xfer;
    logic [15:0] exp_count;

    pixel_dispatcher #(.H_RES(H), .V_RES(V)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (start),
        .abort       (abort),
        .unit_ready  (unit_ready),
        .unit_valid  (unit_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Scoreboard: a job is taken on the coming edge when the offered unit is ready.
    always @(negedge aclk) begin
        job_t       e;
        logic [2:0] u;
        if (aresetn && ((unit_valid & unit_ready) != 4'b0)) begin
            n_xfer++;
            case (unit_valid)
                4'b0001: u = 3'd0;
                4'b0010: u = 3'd1;
                4'b0100: u = 3'd2;
                4'b1000: u = 3'd3;
                default: u = 3'd7;
            endcase
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: job x=%0d y=%0d unit=%0d but none expected", pix_x, pix_y, u);
            end else begin
                e = exp_q.pop_front();
                if ({pix_x, pix_y, u} !== {e.x, e.y, e.u}) begin
                    n_err++;
                    $display("FAIL sb_job: got x=%0d y=%0d unit=%0d, want x=%0d y=%0d unit=%0d",
                             pix_x, pix_y, u, e.x, e.y, e.u);
                end
            end
        end
    end

    task automatic push_frame();
        for (int i = 0; i < NPIX; i++)
            exp_q.push_back('{x: 11'(i % H), y: 10'(i / H), u: 3'(i % 4)});
    endtask

    task automatic start_frame();
        @(posedge aclk); #1;
        start = 1'b1;
        push_frame();
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge aclk);
            if (frame_done) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_done: frame_done not seen within 400 cycles, want a pulse", name);
        end else begin
            exp_count++;
        end
        @(negedge aclk);
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if ({unit_valid, busy, frame_done, frame_count} !== {4'b0, 1'b0, 1'b0, exp_count}) begin
            n_err++;
            $display("FAIL %s_idle: valid=%h busy=%b done=%b count=%0d, want 0 0 0 %0d",
                     name, unit_valid, busy, frame_done, frame_count, exp_count);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_sb_empty: %0d jobs left, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0; start = 1'b0; abort = 1'b0; unit_ready = 4'h0;
        #12;
        n_cmp++;
        if ({unit_valid, pix_x, pix_y, busy, frame_done, frame_count} !== '0) begin
            n_err++;
            $display("FAIL reset: valid=%h x=%0d y=%0d busy=%b done=%b count=%0d, want all 0",
                     unit_valid, pix_x, pix_y, busy, frame_done, frame_count);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check_idle("reset");
    endtask

    task automatic test_full_frame();
        unit_ready = 4'hF;
        start_frame();
        for (int i = 0; i < NPIX; i++) begin
            @(negedge aclk);
            n_cmp++;
            if ({unit_valid, pix_x, pix_y} !== {4'(1 << (i % 4)), 11'(i % H), 10'(i / H)}) begin
                n_err++;
                $display("FAIL full_seq[%0d]: valid=%h x=%0d y=%0d, want %h %0d %0d",
                         i, unit_valid, pix_x, pix_y, 4'(1 << (i % 4)), i % H, i / H);
            end
        end
        @(negedge aclk);
        n_cmp++;
        if ({frame_done, busy, unit_valid, pix_x, pix_y} !== {1'b1, 1'b1, 4'b0, 11'(H - 1), 10'(V - 1)}) begin
            n_err++;
            $display("FAIL full_done: done=%b busy=%b valid=%h x=%0d y=%0d, want 1 1 0 %0d %0d",
                     frame_done, busy, unit_valid, pix_x, pix_y, H - 1, V - 1);
        end
        exp_count++;
        @(negedge aclk);
        check_idle("full");
    endtask

    task automatic test_stall();
        unit_ready = 4'b1101;
        start_frame();
        @(negedge aclk);
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            n_cmp++;
            if ({unit_valid, pix_x, pix_y} !== {4'b0010, 11'd1, 10'd0}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: valid=%h x=%0d y=%0d, want 2 1 0", k, unit_valid, pix_x, pix_y);
            end
        end
        @(posedge aclk); #1;
        unit_ready = 4'hF;
        @(negedge aclk);
        @(negedge aclk);
        n_cmp++;
        if ({unit_valid, pix_x} !== {4'b0100, 11'd2}) begin
            n_err++;
            $display("FAIL stall_release: valid=%h x=%0d, want 4 2", unit_valid, pix_x);
        end
        wait_done("stall");
        check_idle("stall");
    endtask

    task automatic test_abort();
        unit_ready = 4'hF;
        start_frame();
        @(posedge aclk);
        @(posedge aclk); #1;
        abort = 1'b1;
        @(posedge aclk); #1;
        abort = 1'b0;
        @(negedge aclk);
        n_cmp++;
        if (exp_q.size() != NPIX - 3) begin
            n_err++;
            $display("FAIL abort_issued: %0d jobs left, want %0d", exp_q.size(), NPIX - 3);
        end
        exp_q.delete();
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge aclk);
            n_cmp++;
            if ({unit_valid, busy, frame_done, frame_count} !== {4'b0, 1'b0, 1'b0, exp_count}) begin
                n_err++;
                $display("FAIL abort_quiet[%0d]: valid=%h busy=%b done=%b count=%0d, want 0 0 0 %0d",
                         c, unit_valid, busy, frame_done, frame_count, exp_count);
            end
        end
        @(posedge aclk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge aclk);
        n_cmp++;
        if ({busy, unit_valid} !== 5'b0) begin
            n_err++;
            $display("FAIL abort_wins: busy=%b valid=%h, want 0 0", busy, unit_valid);
        end
        start_frame();
        @(negedge aclk);
        n_cmp++;
        if ({unit_valid, pix_x, pix_y} !== {4'b0001, 11'd0, 10'd0}) begin
            n_err++;
            $display("FAIL abort_resume: valid=%h x=%0d y=%0d, want 1 0 0", unit_valid, pix_x, pix_y);
        end
        wait_done("abort");
        check_idle("abort");
    endtask

    task automatic test_back_to_back();
        unit_ready = 4'hF;
        @(posedge aclk); #1;
        start = 1'b1;
        for (int f = 0; f < 3; f++) push_frame();
        @(posedge aclk);
        for (int t = 0; t < 30; t++) begin
            @(negedge aclk);
            n_cmp++;
            if ({unit_valid != 4'b0, frame_done, busy} !== {(t % 10) < 8, (t % 10) == 8, (t % 10) != 9}) begin
                n_err++;
                $display("FAIL b2b[%0d]: valid=%h done=%b busy=%b, want valid %0s done %b busy %b",
                         t, unit_valid, frame_done, busy, ((t % 10) < 8) ? "on" : "off",
                         (t % 10) == 8, (t % 10) != 9);
            end
        end
        start = 1'b0;
        exp_count += 16'd3;
        @(negedge aclk);
        check_idle("b2b");
    endtask

    task automatic test_reset_mid();
        unit_ready = 4'hF;
        start_frame();
        @(posedge aclk);
        @(posedge aclk); #2;
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({unit_valid, pix_x, pix_y, busy, frame_done, frame_count} !== '0) begin
            n_err++;
            $display("FAIL rst_async: valid=%h x=%0d y=%0d busy=%b done=%b count=%0d, want all 0",
                     unit_valid, pix_x, pix_y, busy, frame_done, frame_count);
        end
        exp_q.delete();
        exp_count = 16'd0;
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            n_cmp++;
            if ({frame_done, busy} !== 2'b0) begin
                n_err++;
                $display("FAIL rst_no_done[%0d]: done=%b busy=%b, want 0 0", c, frame_done, busy);
            end
        end
        test_full_frame();
    endtask

    task automatic test_random_stalls();
        for (int f = 0; f < 2; f++) begin
            bit seen = 1'b0;
            n_xfer = 0;
            unit_ready = 4'($urandom);
            start_frame();
            for (int c = 0; c < 400 && !seen; c++) begin
                @(negedge aclk);
                if (frame_done) seen = 1'b1;
                @(posedge aclk); #1;
                unit_ready = 4'($urandom);
            end
            n_cmp++;
            if (!seen) begin
                n_err++;
                $display("FAIL rand_done[%0d]: frame_done not seen, want a pulse", f);
            end else begin
                exp_count++;
            end
            unit_ready = 4'h0;
            @(negedge aclk);
            n_cmp++;
            if (n_xfer != NPIX) begin
                n_err++;
                $display("FAIL rand_jobs[%0d]: %0d jobs, want %0d", f, n_xfer, NPIX);
            end
            check_idle("rand");
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_xfer = 0; exp_count = 16'd0;
        test_reset();
        test_full_frame();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random_stalls();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish in 300000 ns");
        $fatal(1, "timeout");
    end

endmodule
